ks_serial_add_arbiter: RTL and testbench

Shares a single 4-bit Kogge-Stone adder slice between two requesters and sequences it nibble-serially to perform WIDTH-bit add/subtract operations. The block arbitrates round-robin between the requesters, captures operands on a valid/ready handshake, runs one nibble per cycle through the shared slice with a registered carry, and presents the result on a valid/ready output port tagged with the requester ID. It sits between operand producers and the arithmetic datapath as its only controller.

---
 rtl/ks_ctrl_pkg.sv | 17 +
 rtl/ks_adder4_cin.sv | 40 ++++
 rtl/ks_serial_add_arbiter.sv | 134 +++++++++++++
 tb/tb_ks_serial_add_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ks_ctrl_pkg.sv
// Shared types and constants for the nibble-serial Kogge-Stone add/subtract controller.
package ks_ctrl_pkg;

  localparam int NIB = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Slice index needs at least one bit even when there is only a single slice.
  function automatic int idx_width(input int nslice);
    return (nslice <= 1) ? 1 : $clog2(nslice);
  endfunction

endpackage

// File: rtl/ks_adder4_cin.sv
// Purely combinational 4-bit Kogge-Stone adder with carry-in.
module ks_adder4_cin
  import ks_ctrl_pkg::*;
(
  input  logic [NIB-1:0] a,
  input  logic [NIB-1:0] b,
  input  logic           cin,
  output logic [NIB-1:0] sum,
  output logic           cout
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] g1;
  logic [3:2] p1;
  logic [3:0] g2;

  // Carry-in folds into bit 0's generate so the prefix tree yields carries directly.
  always_comb begin
    p     = a ^ b;
    g     = a & b;
    g[0]  = g[0] | (p[0] & cin);

    g1[0] = g[0];
    g1[1] = g[1] | (p[1] & g[0]);
    g1[2] = g[2] | (p[2] & g[1]);
    g1[3] = g[3] | (p[3] & g[2]);
    p1[2] = p[2] & p[1];
    p1[3] = p[3] & p[2];

    g2[0] = g1[0];
    g2[1] = g1[1];
    g2[2] = g1[2] | (p1[2] & g1[0]);
    g2[3] = g1[3] | (p1[3] & g1[1]);

    sum   = p ^ {g2[2:0], cin};
    cout  = g2[3];
  end

endmodule

// File: rtl/ks_serial_add_arbiter.sv
// Round-robin arbiter that shares one 4-bit Kogge-Stone slice between two requesters,
// running WIDTH-bit add/subtract one nibble per cycle with a registered carry.
module ks_serial_add_arbiter
  import ks_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [1:0]         req_sub,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [WIDTH-1:0]   res_sum,
  output logic               res_cout,
  output logic               res_id,
  output logic               busy
);

  localparam int NSLICE = WIDTH / NIB;
  localparam int IDXW   = idx_width(NSLICE);

  state_e            state_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  sum_q;
  logic [WIDTH-1:0]  sum_d;
  logic [IDXW-1:0]   idx_q;
  logic              carry_q;
  logic              cout_q;
  logic              id_q;
  logic              last_grant_q;
  logic              valid_q;
  logic              busy_q;

  logic              grant;
  logic              grant_vld;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic              op_sub;
  logic [WIDTH-1:0]  b_d;
  logic [31:0]       shamt;
  logic [NIB-1:0]    a_nib;
  logic [NIB-1:0]    b_nib;
  logic [NIB-1:0]    slice_sum;
  logic              slice_cout;
  logic              last_slice;

  // Contested cycles go to whoever was not served last; otherwise the lone requester wins.
  always_comb begin
    grant_vld = |req_valid;
    grant     = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
    op_a      = grant ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
    op_b      = grant ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
    op_sub    = grant ? req_sub[1] : req_sub[0];
    b_d       = op_sub ? ~op_b : op_b;
  end

  assign req_ready = (!rst && state_q == IDLE && grant_vld) ? (2'b01 << grant) : 2'b00;

  assign shamt      = 32'(idx_q) * 32'(NIB);
  assign a_nib      = NIB'(a_q >> shamt);
  assign b_nib      = NIB'(b_q >> shamt);
  assign last_slice = (idx_q == IDXW'(NSLICE - 1));
  assign sum_d      = (sum_q & ~(WIDTH'(4'hF) << shamt)) | (WIDTH'(slice_sum) << shamt);

  ks_adder4_cin u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Subtraction is A + ~B + 1: the inverted B is captured and the carry seeded with 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      idx_q        <= '0;
      carry_q      <= 1'b0;
      cout_q       <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            a_q     <= op_a;
            b_q     <= b_d;
            carry_q <= op_sub;
            idx_q   <= '0;
            id_q    <= grant;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= slice_cout;
          idx_q   <= idx_q + IDXW'(1);
          if (last_slice) begin
            cout_q  <= slice_cout;
            valid_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            last_grant_q <= id_q;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign res_valid = valid_q;
  assign res_sum   = sum_q;
  assign res_cout  = cout_q;
  assign res_id    = id_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ks_serial_add_arbiter.sv
// Scenario bench for ks_serial_add_arbiter: accepted requests feed a scoreboard queue,
// results are popped and compared as they appear.
module tb_ks_serial_add_arbiter;

  localparam int WIDTH  = 16;
  localparam int NSLICE = WIDTH / 4;
  localparam int EW     = WIDTH + 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [1:0]         req_valid = '0;
  logic [1:0]         req_ready;
  logic [2*WIDTH-1:0] req_a = '0;
  logic [2*WIDTH-1:0] req_b = '0;
  logic [1:0]         req_sub = '0;
  logic               res_valid;
  logic               res_ready = 1'b1;
  logic [WIDTH-1:0]   res_sum;
  logic               res_cout;
  logic               res_id;
  logic               busy;

  logic [EW-1:0] expQ[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ks_serial_add_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
    .res_id    (res_id),
    .busy      (busy)
  );

  function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                          input logic sub, input logic id);
    logic [WIDTH:0] r;
    if (sub) r = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    else     r = {1'b0, a} + {1'b0, b};
    return {r[WIDTH-1:0], r[WIDTH], id};
  endfunction

  // Every accepted request pushes its expected {sum, cout, id}.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i])
          expQ.push_back(model(req_a[i*WIDTH +: WIDTH], req_b[i*WIDTH +: WIDTH], req_sub[i], 1'(i)));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic sub);
    bit got = 1'b0;
    req_a[id*WIDTH +: WIDTH] = a;
    req_b[id*WIDTH +: WIDTH] = b;
    req_sub[id]   = sub;
    req_valid[id] = 1'b1;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      got = req_ready[id];
    end
    tick();
    req_valid[id] = 1'b0;
    total++;
    if (!got) begin
      bad++;
      $display("[TB] FAIL grant_timeout: req_ready=%b, required bit %0d set", req_ready, id);
    end
  endtask

  task automatic wait_valid(output int n);
    n = -1;
    for (int k = 1; k <= 40 && n < 0; k++) begin
      @(negedge clk);
      if (res_valid) n = k;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0;
    res_ready = 1'b1;
    tick();
    tick();
    total++;
    if ({req_ready, res_valid, res_sum, res_cout, res_id, busy} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_values: got rdy=%b v=%b sum=%h c=%b id=%b busy=%b, required all zero",
               req_ready, res_valid, res_sum, res_cout, res_id, busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_arith();
    int               tid[4]   = '{0, 1, 1, 0};
    logic [WIDTH-1:0] ta[4]    = '{16'h1234, 16'hFFFF, 16'h0005, 16'h0007};
    logic [WIDTH-1:0] tb[4]    = '{16'h0FFF, 16'h0001, 16'h0007, 16'h0005};
    logic             ts[4]    = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [WIDTH-1:0] tsum[4]  = '{16'h2233, 16'h0000, 16'hFFFE, 16'h0002};
    logic             tcout[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [EW-1:0]    exp;
    int               n;
    for (int t = 0; t < 4; t++) begin
      issue(tid[t], ta[t], tb[t], ts[t]);
      wait_valid(n);
      total++;
      if (n !== NSLICE + 1) begin
        bad++;
        $display("[TB] FAIL latency[%0d]: got %0d cycles, required %0d", t, n, NSLICE + 1);
      end
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL scoreboard[%0d]: got empty queue, required one entry", t);
      end else begin
        exp = expQ.pop_front();
        if ({res_sum, res_cout, res_id} !== exp) begin
          bad++;
          $display("[TB] FAIL scoreboard[%0d]: got %h/%b/%b, required %h/%b/%b", t,
                   res_sum, res_cout, res_id, exp[EW-1:2], exp[1], exp[0]);
        end
      end
      total++;
      if ({res_sum, res_cout} !== {tsum[t], tcout[t]}) begin
        bad++;
        $display("[TB] FAIL arith[%0d]: got %h cout %b, required %h cout %b", t,
                 res_sum, res_cout, tsum[t], tcout[t]);
      end
      tick();
      total++;
      if ({res_valid, busy} !== 2'b00) begin
        bad++;
        $display("[TB] FAIL release[%0d]: got valid=%b busy=%b, required 0 0", t, res_valid, busy);
      end
    end
  endtask

  task automatic test_alternate();
    logic [EW-1:0] exp;
    int            n;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_a     = {16'h00F0, 16'h0F0F};
    req_b     = {16'h0011, 16'hF0F1};
    req_sub   = 2'b10;
    req_valid = 2'b11;
    @(negedge clk);
    total++;
    if (req_ready !== 2'b01) begin
      bad++;
      $display("[TB] FAIL first_grant: got %b, required 01", req_ready);
    end
    for (int k = 0; k < 4; k++) begin
      wait_valid(n);
      total++;
      if (n < 0) begin
        bad++;
        $display("[TB] FAIL alt_timeout[%0d]: got no res_valid, required one", k);
      end
      total++;
      if (res_id !== 1'(k % 2)) begin
        bad++;
        $display("[TB] FAIL alt_order[%0d]: got id %b, required %0d", k, res_id, k % 2);
      end
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL alt_scoreboard[%0d]: got empty queue, required one entry", k);
      end else begin
        exp = expQ.pop_front();
        if ({res_sum, res_cout, res_id} !== exp) begin
          bad++;
          $display("[TB] FAIL alt_scoreboard[%0d]: got %h/%b/%b, required %h/%b/%b", k,
                   res_sum, res_cout, res_id, exp[EW-1:2], exp[1], exp[0]);
        end
      end
      tick();
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [EW-1:0] exp;
    int            n;
    res_ready = 1'b0;
    issue(1, 16'hABCD, 16'h1111, 1'b0);
    wait_valid(n);
    total++;
    if (expQ.size() == 0 || n < 0) begin
      bad++;
      $display("[TB] FAIL bp_scoreboard: got queue=%0d latency=%0d, required entry and result",
               expQ.size(), n);
    end else begin
      exp = expQ.pop_front();
      if ({res_sum, res_cout, res_id} !== exp) begin
        bad++;
        $display("[TB] FAIL bp_scoreboard: got %h/%b/%b, required %h/%b/%b",
                 res_sum, res_cout, res_id, exp[EW-1:2], exp[1], exp[0]);
      end
    end
    tick();
    req_valid = 2'b11;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if ({res_valid, res_sum, res_cout, res_id, req_ready, busy} !==
          {1'b1, 16'hBCDE, 1'b0, 1'b1, 2'b00, 1'b1}) begin
        bad++;
        $display("[TB] FAIL hold[%0d]: got v=%b sum=%h c=%b id=%b rdy=%b busy=%b, required 1 bcde 0 1 00 1",
                 c, res_valid, res_sum, res_cout, res_id, req_ready, busy);
      end
    end
    tick();
    req_valid = '0;
    res_ready = 1'b1;
    tick();
    total++;
    if (res_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL bp_release: got res_valid %b, required 0", res_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [EW-1:0] exp;
    int            n;
    issue(0, 16'h1111, 16'h2222, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expQ.delete();
    total++;
    if ({busy, res_valid, req_ready} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL mid_reset: got busy=%b v=%b rdy=%b, required 0 0 00", busy, res_valid, req_ready);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      total++;
      if (res_valid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL discarded[%0d]: got res_valid %b, required 0", c, res_valid);
      end
    end
    tick();
    issue(1, 16'h8000, 16'h8000, 1'b0);
    wait_valid(n);
    total++;
    if (n !== NSLICE + 1) begin
      bad++;
      $display("[TB] FAIL post_latency: got %0d cycles, required %0d", n, NSLICE + 1);
    end
    total++;
    if (expQ.size() == 0) begin
      bad++;
      $display("[TB] FAIL post_scoreboard: got empty queue, required one entry");
    end else begin
      exp = expQ.pop_front();
      if ({res_sum, res_cout, res_id} !== exp) begin
        bad++;
        $display("[TB] FAIL post_scoreboard: got %h/%b/%b, required %h/%b/%b",
                 res_sum, res_cout, res_id, exp[EW-1:2], exp[1], exp[0]);
      end
    end
    total++;
    if ({res_sum, res_cout, res_id} !== {16'h0000, 1'b1, 1'b1}) begin
      bad++;
      $display("[TB] FAIL post_result: got %h/%b/%b, required 0000/1/1", res_sum, res_cout, res_id);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_arith();
    test_alternate();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
